// File: rtl/bus_cycle_master.sv
// Purpose: turns single-byte read/write requests into 8088 minimum-mode T1-T4 bus cycles with address/CS decode.
// Latency: the response pulses in T3, the third cycle counted from the cycle holding the accepting handshake; 4 cycles per transfer back-to-back.
// Backpressure: REQ_READY is high only in IDLE/T4; a requester must hold its request until it sees READY at a rising edge.
`timescale 1ns/1ps

module bus_cycle_master #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int IO_SEL_BIT = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // request side
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic                  REQ_IO,
  input  logic [ADDR_WIDTH:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  // response side
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  // demultiplexed 8088-style bus
  output logic                  ALE,
  output logic                  RD,
  output logic                  WR,
  output logic                  IO_M,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [3:0]            CS,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  // Bus cycle phases; encoding kept as plain constants so legacy
  // tooling that greps for state values keeps working.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;

  // Chip select one-hot codes
  localparam logic [3:0] CS_MEM_LO = 4'b0001;
  localparam logic [3:0] CS_MEM_HI = 4'b0010;
  localparam logic [3:0] CS_IO0    = 4'b0100;
  localparam logic [3:0] CS_IO1    = 4'b1000;

  // FSM state
  logic [2:0]            state_q, state_d;

  // Captured request. Address and space are held in their decoded form
  // (ADDRESS/CS/IO_M registers) since nothing needs the raw copy later.
  logic                  req_wr_q, req_wr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;

  // Registered bus outputs
  logic                  ale_q, ale_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  io_m_q, io_m_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [3:0]            cs_q, cs_d;
  logic                  data_oe_q, data_oe_d;

  // Registered response outputs
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // Decode results for the request currently on the input port
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [3:0]            dec_cs;
  logic [ADDR_WIDTH-1:0] io_addr;
  logic                  accept;

  // Request acceptance is allowed only between bus cycles (IDLE) or
  // during the turnaround cycle (T4), which gives 4-cycle back-to-back.
  always_comb begin
    REQ_READY = (state_q == S_IDLE) || (state_q == S_T4);
  end

  assign accept = REQ_VALID && REQ_READY;

  // Address/chip-select decode of the incoming request. IO space only
  // carries 16 address bits; the upper bits are forced to zero.
  always_comb begin
    io_addr       = '0;
    io_addr[15:0] = REQ_ADDR[15:0];
    if (REQ_IO) begin
      dec_addr = io_addr;
      dec_cs   = REQ_ADDR[IO_SEL_BIT] ? CS_IO1 : CS_IO0;
    end else begin
      dec_addr = REQ_ADDR[ADDR_WIDTH-1:0];
      dec_cs   = REQ_ADDR[ADDR_WIDTH] ? CS_MEM_HI : CS_MEM_LO;
    end
  end

  // Next-state and next-output logic. Every output is computed one
  // phase ahead so the register holds the value for the whole phase.
  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_wdata_d = req_wdata_q;
    ale_d       = ale_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    io_m_d      = io_m_q;
    address_d   = address_q;
    cs_d        = cs_q;
    data_oe_d   = data_oe_q;
    rsp_vld_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE, S_T4: begin
        if (accept) begin
          // Launch T1: address, selects and space become valid with ALE.
          state_d     = S_T1;
          req_wr_d    = REQ_WRITE;
          req_wdata_d = REQ_WDATA;
          ale_d       = 1'b1;
          rd_n_d      = 1'b1;
          wr_n_d      = 1'b1;
          io_m_d      = REQ_IO;
          address_d   = dec_addr;
          cs_d        = dec_cs;
          data_oe_d   = 1'b0;
        end else begin
          // Turnaround values from T4 simply persist while idle;
          // ADDRESS and IO_M keep their last values.
          state_d = S_IDLE;
        end
      end

      S_T1: begin
        // Slaves have latched the address; assert the strobe for T2.
        state_d = S_T2;
        ale_d   = 1'b0;
        if (req_wr_q) begin
          wr_n_d    = 1'b0;
          data_oe_d = 1'b1;
        end else begin
          rd_n_d = 1'b0;
        end
      end

      S_T2: begin
        // Read data is sampled on the edge that ends T2; the response
        // pulse lines up with T3.
        state_d   = S_T3;
        rsp_vld_d = 1'b1;
        if (!req_wr_q) begin
          rsp_rdata_d = DATA;
        end
      end

      S_T3: begin
        // Release strobes, selects and the data bus for turnaround.
        state_d   = S_T4;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        cs_d      = '0;
        data_oe_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any cycle in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      req_wr_q    <= 1'b0;
      req_wdata_q <= '0;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      io_m_q      <= 1'b0;
      address_q   <= '0;
      cs_q        <= '0;
      data_oe_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_wdata_q <= req_wdata_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      io_m_q      <= io_m_d;
      address_q   <= address_d;
      cs_q        <= cs_d;
      data_oe_q   <= data_oe_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ALE       = ale_q;
  assign RD        = rd_n_q;
  assign WR        = wr_n_q;
  assign IO_M      = io_m_q;
  assign ADDRESS   = address_q;
  assign CS        = cs_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_RDATA = rsp_rdata_q;

  // Write data comes straight from the captured request register, so the
  // bus value cannot change if the requester alters REQ_WDATA mid-cycle.
  assign DATA = data_oe_q ? req_wdata_q : {DATA_WIDTH{1'bz}};

  // Structural invariants of the bus protocol
  a_cs_onehot0: assert property (@(posedge CLK) disable iff (RESET)
    $onehot0(cs_q));
  a_cs_active: assert property (@(posedge CLK) disable iff (RESET)
    (state_q == S_T1 || state_q == S_T2 || state_q == S_T3) |-> $onehot(cs_q));
  a_strobes_exclusive: assert property (@(posedge CLK) disable iff (RESET)
    !(!rd_n_q && !wr_n_q));
  a_drive_write_only: assert property (@(posedge CLK) disable iff (RESET)
    data_oe_q |-> (req_wr_q && (state_q == S_T2 || state_q == S_T3)));

endmodule
